// File: rtl/decode_hazard_scoreboard.sv
// decode_hazard_scoreboard
// Issue controller for the decode stage. It keeps a pending-write counter for
// each architectural register and stalls decode while a source still has an
// uncommitted write. It also serialises issue behind writes to R15 (the PC).
//
// Optional build macro: SCOREBOARD_WB_BYPASS_EN
//   When this macro is defined, a register that is retiring its last
//   in-flight write in the current cycle is treated as already free. This
//   applies to source hazards, to the full check and to the PC_WAIT exit.
//   The register file must therefore write through in that cycle.
module decode_hazard_scoreboard #(
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_a1,
    input  logic [ADDR_W-1:0] dec_a2,
    input  logic              dec_use_a1,
    input  logic              dec_use_a2,
    input  logic              dec_wr,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_a3,
    output logic              stall,
    output logic              issue,
    output logic [NREGS-1:0]  busy,
    output logic              pc_wait,
    output logic              err
);

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PC_REG  = ADDR_W'(NREGS - 1);

    typedef enum logic {
        RUN     = 1'b0,
        PC_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt      [NREGS];
    logic [CNT_W-1:0]  cnt_next [NREGS];
    logic              hazard;
    logic              full;
    logic              run_mode;
    logic              bypass_a1;
    logic              bypass_a2;
    logic              bypass_rd;
    logic              pc_release;
    logic              err_set;

    // Reads of the PC never hazard because the PC value is supplied directly.
    function automatic logic src_hazard(input logic              use_src,
                                        input logic [ADDR_W-1:0] src,
                                        input logic [CNT_W-1:0]  src_cnt,
                                        input logic              bypassed);
        return use_src && (src_cnt != '0) && (src != PC_REG) && !bypassed;
    endfunction

    // Determine which pending writes retire early enough to be bypassed this cycle.
    always_comb begin
`ifdef SCOREBOARD_WB_BYPASS_EN
        bypass_a1  = wb_valid && (wb_a3 == dec_a1) && (cnt[dec_a1] == CNT_ONE);
        bypass_a2  = wb_valid && (wb_a3 == dec_a2) && (cnt[dec_a2] == CNT_ONE);
        bypass_rd  = wb_valid && (wb_a3 == dec_rd);
        pc_release = wb_valid && (wb_a3 == PC_REG) && (cnt[PC_REG] == CNT_ONE);
`else
        bypass_a1  = 1'b0;
        bypass_a2  = 1'b0;
        bypass_rd  = 1'b0;
        pc_release = 1'b0;
`endif
    end

    // Issue decision. The stall and issue outputs are forced low while reset is asserted.
    always_comb begin
        hazard   = src_hazard(dec_use_a1, dec_a1, cnt[dec_a1], bypass_a1) ||
                   src_hazard(dec_use_a2, dec_a2, cnt[dec_a2], bypass_a2);
        full     = dec_wr && (cnt[dec_rd] == CNT_MAX) && !bypass_rd;
        run_mode = (state == RUN) || pc_release;
        issue    = !reset && run_mode && dec_valid && !hazard && !full;
        stall    = !reset && dec_valid && !issue;
    end

    // Next counter values. A retire against an empty counter saturates at zero and raises err.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            logic inc;
            logic dec;
            inc = issue && dec_wr && (dec_rd == ADDR_W'(i));
            dec = wb_valid && (wb_a3 == ADDR_W'(i)) && (cnt[i] != '0);
            cnt_next[i] = cnt[i] + CNT_W'(inc) - CNT_W'(dec);
        end
        err_set = wb_valid && (cnt[wb_a3] == '0);
    end

    // State transition. PC_WAIT is held until the PC counter drains; a new PC write re-enters it.
    always_comb begin
        if (issue && dec_wr && (dec_rd == PC_REG))
            state_next = PC_WAIT;
        else if ((state == PC_WAIT) && (cnt_next[PC_REG] != '0))
            state_next = PC_WAIT;
        else
            state_next = RUN;
    end

    // Register the counters, the FSM state and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
            state <= RUN;
            err   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= cnt_next[i];
            state <= state_next;
            err   <= err | err_set;
        end
    end

    // The busy vector is derived only from the registered counters.
    always_comb begin
        for (int i = 0; i < NREGS; i++) busy[i] = (cnt[i] != '0);
        pc_wait = (state == PC_WAIT);
    end

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Directed self-checking bench for decode_hazard_scoreboard.
module tb_decode_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [3:0]  dec_a1;
    logic [3:0]  dec_a2;
    logic        dec_use_a1;
    logic        dec_use_a2;
    logic        dec_wr;
    logic [3:0]  dec_rd;
    logic        wb_valid;
    logic [3:0]  wb_a3;
    logic        stall;
    logic        issue;
    logic [15:0] busy;
    logic        pc_wait;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    decode_hazard_scoreboard #(.NREGS(16), .ADDR_W(4), .CNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_a1     (dec_a1),
        .dec_a2     (dec_a2),
        .dec_use_a1 (dec_use_a1),
        .dec_use_a2 (dec_use_a2),
        .dec_wr     (dec_wr),
        .dec_rd     (dec_rd),
        .wb_valid   (wb_valid),
        .wb_a3      (wb_a3),
        .stall      (stall),
        .issue      (issue),
        .busy       (busy),
        .pc_wait    (pc_wait),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_a1 = 0; dec_a2 = 0; dec_use_a1 = 0; dec_use_a2 = 0;
        dec_wr = 0; dec_rd = 0; wb_valid = 0; wb_a3 = 0;
    endtask

    task automatic req(input logic ua1, input logic [3:0] a1, input logic ua2,
                       input logic [3:0] a2, input logic wr, input logic [3:0] rd);
        dec_valid = 1; dec_use_a1 = ua1; dec_a1 = a1; dec_use_a2 = ua2; dec_a2 = a2;
        dec_wr = wr; dec_rd = rd;
    endtask

    task automatic retire(input logic [3:0] a3);
        wb_valid = 1; wb_a3 = a3;
    endtask

    initial begin
        idle();
        reset = 1;
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_issue", issue, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc_wait", pc_wait, 0);
        chk("rst_err", err, 0);
        cyc();
        reset = 0;
        cyc();

        // R15 read with no pending write issues immediately
        req(1, 15, 0, 0, 0, 0);
        #1;
        chk("r15_issue", issue, 1);
        chk("r15_stall", stall, 0);
        cyc();

        // Reset in the middle of a stall
        req(0, 0, 0, 0, 1, 3);
        #1;
        chk("wr3_issue", issue, 1);
        cyc();
        req(1, 3, 0, 0, 0, 0);
        #1;
        chk("r3_busy", busy, 16'h0008);
        chk("r3_stall", stall, 1);
        chk("r3_issue", issue, 0);
        reset = 1;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_issue", issue, 0);
        cyc();
        reset = 0;
        #1;
        chk("postrst_issue", issue, 1);
        chk("postrst_stall", stall, 0);
        cyc();

        // RAW hazard on R2
        req(0, 0, 0, 0, 1, 2);
        #1;
        chk("wr2_issue", issue, 1);
        cyc();
        req(0, 0, 1, 2, 0, 0);
        #1;
        chk("raw_stall", stall, 1);
        chk("raw_issue", issue, 0);
        chk("raw_busy", busy, 16'h0004);
        cyc();
        retire(2);
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        chk("raw_wb_issue", issue, 1);
`else
        chk("raw_wb_issue", issue, 0);
        chk("raw_wb_stall", stall, 1);
`endif
        cyc();
        wb_valid = 0;
        #1;
        chk("raw_after_issue", issue, 1);
        chk("raw_after_busy", busy, 0);
        cyc();

        // Branch serialisation behind a write to R15
        req(0, 0, 0, 0, 1, 15);
        #1;
        chk("br_issue", issue, 1);
        chk("br_pc_wait0", pc_wait, 0);
        cyc();
        req(0, 0, 0, 0, 0, 0);
        #1;
        chk("br_pc_wait1", pc_wait, 1);
        chk("br_stall", stall, 1);
        chk("br_hold_issue", issue, 0);
        chk("br_busy", busy, 16'h8000);
        cyc();
        #1;
        chk("br_stall2", stall, 1);
        retire(15);
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        chk("br_wb_issue", issue, 1);
`else
        chk("br_wb_issue", issue, 0);
`endif
        chk("br_wb_pc_wait", pc_wait, 1);
        cyc();
        wb_valid = 0;
        #1;
        chk("br_exit_pc_wait", pc_wait, 0);
        chk("br_exit_issue", issue, 1);
        chk("br_exit_busy", busy, 0);
        cyc();

        // Saturation of the R4 counter at three in-flight writes
        req(0, 0, 0, 0, 1, 4);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sat_issue", issue, 1);
            cyc();
        end
        #1;
        chk("sat_busy", busy, 16'h0010);
        chk("sat_stall", stall, 1);
        chk("sat_issue4", issue, 0);
        cyc();
        retire(4);
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        chk("sat_wb_issue", issue, 1);
        cyc();
        idle();
`else
        chk("sat_wb_issue", issue, 0);
        cyc();
        wb_valid = 0;
        #1;
        chk("sat_after_issue", issue, 1);
        cyc();
        idle();
`endif
        // Drain the three remaining R4 writes
        retire(4);
        cyc();
        cyc();
        #1;
        chk("sat_drain_busy_partial", busy, 16'h0010);
        cyc();
        wb_valid = 0;
        #1;
        chk("sat_drain_busy", busy, 0);
        chk("sat_drain_err", err, 0);

        // Issue and retire of R5 in the same cycle leave the count unchanged
        req(0, 0, 0, 0, 1, 5);
        cyc();
        retire(5);
        #1;
        chk("same_issue", issue, 1);
        cyc();
        idle();
        #1;
        chk("same_busy", busy, 16'h0020);
        retire(5);
        cyc();
        wb_valid = 0;
        #1;
        chk("same_one_left", busy, 0);
        chk("same_err", err, 0);

        // Retire against an empty R7 counter sets the sticky error
        retire(7);
        #1;
        chk("err_before", err, 0);
        cyc();
        wb_valid = 0;
        #1;
        chk("err_set", err, 1);
        chk("err_busy", busy, 0);
        cyc();
        cyc();
        #1;
        chk("err_sticky", err, 1);
        reset = 1;
        #1;
        chk("err_cleared", err, 0);
        cyc();
        reset = 0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_hazard_scoreboard.md
Name: decode_hazard_scoreboard

Overview:
- Issue controller for the decode stage and its 16-entry register file.
- Tracks in-flight writes per register (pending counters) and stalls decode while a source register (A1/A2) still has an uncommitted write.
- Issues each valid decoded instruction to execute and retires writes on the writeback port (regWrite/A3).
- Holds issue after a write to R15 (PC) until that write retires, which serialises branches.

Parameters:
- NREGS, 16, number of architectural registers (R15 = PC).
- ADDR_W, 4, register address width.
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- dec_valid  input  1  decode holds a valid instruction.
- dec_a1  input  ADDR_W  source register A1.
- dec_a2  input  ADDR_W  source register A2.
- dec_use_a1  input  1  instruction reads A1.
- dec_use_a2  input  1  instruction reads A2.
- dec_wr  input  1  instruction writes Rd.
- dec_rd  input  ADDR_W  destination register.
- wb_valid  input  1  writeback commits this cycle (regWrite).
- wb_a3  input  ADDR_W  writeback register address (A3).
- stall  output  1  hold fetch/decode registers.
- issue  output  1  decode->execute valid this cycle.
- busy  output  NREGS  bit i = 1 when counter[i] != 0.
- pc_wait  output  1  FSM in PC_WAIT.
- err  output  1  sticky; retire with zero count.

Behaviour:
- Reset (async, any cycle, mid-operation included): all counters 0, FSM=RUN, err=0. Outputs during reset: stall=0, issue=0, busy=0, pc_wait=0.
- hazard = (dec_use_a1 && cnt[dec_a1]!=0 && dec_a1!=15) || (same for A2). Reads of R15 never hazard, because the PC value is supplied directly.
- full = dec_wr && cnt[dec_rd]==max.
- RUN state:
  - issue = dec_valid && !hazard && !full.
  - stall = dec_valid && !issue.
  - Combinational, no added latency.
- PC_WAIT state: issue=0; stall=dec_valid.
- Transitions:
  - RUN->PC_WAIT when issue && dec_wr && dec_rd==15.
  - PC_WAIT->RUN on the clock edge where cnt[15] becomes 0. Issue resumes the following cycle.
- Counter update at posedge:
  - cnt[dec_rd] += (issue && dec_wr).
  - cnt[wb_a3] -= wb_valid.
  - Issue and retire to the same register in the same cycle: net unchanged.
- Retire with cnt[wb_a3]==0: counter stays 0 (no wrap), err set and held until reset.
- Counter saturation: never exceeded, because the full term forces stall.
- A retire on cycle t clears the hazard from cycle t+1 (the register-file write lands at edge t). Without bypass, this costs a one-cycle bubble minimum.
- busy reflects registered counters only.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: a source whose counter equals 1 and that is retiring this cycle (wb_valid && wb_a3==src) does not hazard, so issue occurs the same cycle the writeback retires. The register file must write-through in that cycle. The same rule applies to full: a destination at max that is also retiring is not full. It also applies to PC_WAIT: exit is combinational when cnt[15]==1 and R15 is retiring.
- Undefined: the rules above, with a one-cycle bubble after retire.

Test Plan:
- Reset mid-stall: cnt[3]=1, dec_valid with A1=3 → stall=1. Assert reset → stall=0, busy=0 immediately. Release reset → same request issues.
- RAW hazard: issue wr R2, next instruction reads A2=2 → stall=1, issue=0. wb_valid,wb_a3=2 at cycle t → issue=1 at t+1, or at t when SCOREBOARD_WB_BYPASS_EN is defined.
- R15 read: dec_use_a1=1, dec_a1=15, cnt[15]=0 → issue=1 with no stall.
- Branch serialise: issue wr R15 → pc_wait=1; dec_valid held high → stall=1. wb_a3=15 retire → pc_wait=0 next cycle, issue resumes.
- Saturation: three issues writing R4 with no retire → busy[4]=1. Fourth issue to R4 → stall=1. One retire → fourth issues.
- Simultaneous events and error:
  - Same-cycle issue wr R5 with retire R5 (cnt[5]=1) → cnt[5] stays 1.
  - Retire R7 with cnt[7]=0 → err=1 sticky, cnt[7]=0.
